// File: rtl/stack_pointer_ctrl.sv
// stack_pointer_ctrl: push/pop/set front end for a cascaded 74x169 stack-pointer counter chain
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous reset, active low
//   push_i         request decrement (stack grows down), sampled in IDLE only
//   pop_i          request increment, sampled in IDLE only
//   set_i          request load of set_value_i, sampled in IDLE only
//   set_value_i    value captured when a set is accepted
//   clear_flags_i  clears overflow_o/underflow_o
//   cnt_q_i        counter chain outputs
//   cnt_load_o     chain load strobe, active low
//   cnt_ud_o       chain direction, 1 = up
//   cnt_en_o       chain enp / first-stage ent, active low
//   cnt_d_o        chain parallel data
//   busy_o         request in flight or initialising
//   ack_o          one-cycle completion pulse
//   err_o          qualifies ack_o: request refused at a limit
//   overflow_o     sticky: push refused at zero
//   underflow_o    sticky: pop refused at all ones
module stack_pointer_ctrl #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] BASE = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             set_i,
    input  logic [WIDTH-1:0] set_value_i,
    input  logic             clear_flags_i,
    input  logic [WIDTH-1:0] cnt_q_i,
    output logic             cnt_load_o,
    output logic             cnt_ud_o,
    output logic             cnt_en_o,
    output logic [WIDTH-1:0] cnt_d_o,
    output logic             busy_o,
    output logic             ack_o,
    output logic             err_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    typedef enum logic [2:0] {INIT, IDLE, STEP, LOAD, DONE} state_t;
    state_t           state_q;
    logic             cnt_load_q, cnt_ud_q, cnt_en_q, busy_q, ack_q, err_q, ovf_q, unf_q;
    logic             fail_q;
    logic [WIDTH-1:0] cnt_d_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= INIT;
            cnt_load_q <= 1'b0;
            cnt_d_q    <= BASE;
            cnt_en_q   <= 1'b1;
            cnt_ud_q   <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            // A refusal later in this block overrides the clear (set wins)
            ovf_q <= ovf_q & ~clear_flags_i;
            unf_q <= unf_q & ~clear_flags_i;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                INIT: begin
                    cnt_load_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                IDLE: begin
                    if (set_i) begin
                        cnt_d_q    <= set_value_i;
                        cnt_load_q <= 1'b0;
                        busy_q     <= 1'b1;
                        fail_q     <= 1'b0;
                        state_q    <= LOAD;
                    end else if (pop_i) begin
                        busy_q <= 1'b1;
                        if (&cnt_q_i) begin
                            fail_q  <= 1'b1;
                            unf_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            fail_q   <= 1'b0;
                            cnt_ud_q <= 1'b1;
                            cnt_en_q <= 1'b0;
                            state_q  <= STEP;
                        end
                    end else if (push_i) begin
                        busy_q <= 1'b1;
                        if (cnt_q_i == '0) begin
                            fail_q  <= 1'b1;
                            ovf_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            fail_q   <= 1'b0;
                            cnt_ud_q <= 1'b0;
                            cnt_en_q <= 1'b0;
                            state_q  <= STEP;
                        end
                    end
                end
                STEP, LOAD: begin
                    cnt_en_q   <= 1'b1;
                    cnt_load_q <= 1'b1;
                    state_q    <= DONE;
                end
                DONE: begin
                    ack_q   <= 1'b1;
                    err_q   <= fail_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= INIT;
            endcase
        end
    end
    assign cnt_load_o  = cnt_load_q;
    assign cnt_ud_o    = cnt_ud_q;
    assign cnt_en_o    = cnt_en_q;
    assign cnt_d_o     = cnt_d_q;
    assign busy_o      = busy_q;
    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
endmodule

// File: tb/tb_stack_pointer_ctrl.sv
// tb_stack_pointer_ctrl: directed vector bench with an inline two-stage 74x169 chain model
module tb_stack_pointer_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       push = 1'b0, pop = 1'b0, set = 1'b0, clr = 1'b0;
    logic [7:0] set_value = 8'h00;
    logic [7:0] cnt_q;
    logic       cnt_load, cnt_ud, cnt_en, busy, ack, err, ovf, unf;
    logic [7:0] cnt_d;
    int         n_vec = 0, n_err = 0;

    stack_pointer_ctrl #(.WIDTH(8), .BASE(8'hFF)) dut (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .pop_i(pop), .set_i(set),
        .set_value_i(set_value), .clear_flags_i(clr), .cnt_q_i(cnt_q),
        .cnt_load_o(cnt_load), .cnt_ud_o(cnt_ud), .cnt_en_o(cnt_en), .cnt_d_o(cnt_d),
        .busy_o(busy), .ack_o(ack), .err_o(err), .overflow_o(ovf), .underflow_o(unf)
    );

    always #5 clk = ~clk;

    // Two 74x169 stages: sync load, enp shared, rco of stage 0 feeds ent of stage 1
    always @(posedge clk) begin : chain
        logic       ent_n;
        logic [7:0] nq;
        logic [3:0] q;
        ent_n = cnt_en;
        nq    = cnt_q;
        for (int s = 0; s < 2; s++) begin
            q = cnt_q[4*s +: 4];
            if (!cnt_load) nq[4*s +: 4] = cnt_d[4*s +: 4];
            else if (!cnt_en && !ent_n) nq[4*s +: 4] = cnt_ud ? q + 4'd1 : q - 4'd1;
            ent_n = !(!ent_n && (cnt_ud ? q == 4'hF : q == 4'h0));
        end
        cnt_q <= nq;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       psh, pp, st, cl;
        logic [7:0] sv;
        logic [7:0] q;
        logic       e, o, u;
        int         lat, en, ld;
    } vec_t;

    vec_t vt[20];

    task automatic apply(input vec_t v, input int idx);
        int  en_low = 0, ld_low = 0, lat = 0;
        push = v.psh; pop = v.pp; set = v.st; clr = v.cl; set_value = v.sv;
        @(negedge clk);
        push = 0; pop = 0; set = 0; clr = 0;
        if (!(v.psh || v.pp || v.st)) begin
            chk($sformatf("v%0d_q", idx), cnt_q, v.q);
            chk($sformatf("v%0d_ovf", idx), ovf, v.o);
            chk($sformatf("v%0d_unf", idx), unf, v.u);
            return;
        end
        for (int i = 1; i <= 8; i++) begin
            if (!cnt_en) en_low++;
            if (!cnt_load) ld_low++;
            if (ack) begin lat = i; break; end
            @(negedge clk);
        end
        chk($sformatf("v%0d_lat", idx), lat, v.lat);
        chk($sformatf("v%0d_q", idx), cnt_q, v.q);
        chk($sformatf("v%0d_err", idx), err, v.e);
        chk($sformatf("v%0d_ovf", idx), ovf, v.o);
        chk($sformatf("v%0d_unf", idx), unf, v.u);
        chk($sformatf("v%0d_en_low", idx), en_low, v.en);
        chk($sformatf("v%0d_ld_low", idx), ld_low, v.ld);
        chk($sformatf("v%0d_busy", idx), busy, 0);
        @(negedge clk);
        chk($sformatf("v%0d_ack_pulse", idx), ack, 0);
    endtask

    initial begin
        //          psh pp st cl  sv     q      e  o  u  lat en ld
        vt[0]  = '{1, 0, 0, 0, 8'h00, 8'hFE, 0, 0, 0, 3, 1, 0};
        vt[1]  = '{0, 1, 0, 0, 8'h00, 8'hFF, 0, 0, 0, 3, 1, 0};
        vt[2]  = '{0, 1, 0, 0, 8'h00, 8'hFF, 1, 0, 1, 2, 0, 0};
        vt[3]  = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 3, 0, 1};
        vt[4]  = '{1, 0, 0, 0, 8'h00, 8'h00, 1, 1, 1, 2, 0, 0};
        vt[5]  = '{0, 0, 0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{0, 0, 1, 0, 8'h0F, 8'h0F, 0, 0, 0, 3, 0, 1};
        vt[7]  = '{0, 1, 0, 0, 8'h00, 8'h10, 0, 0, 0, 3, 1, 0};
        vt[8]  = '{1, 0, 0, 0, 8'h00, 8'h0F, 0, 0, 0, 3, 1, 0};
        vt[9]  = '{0, 0, 1, 0, 8'h01, 8'h01, 0, 0, 0, 3, 0, 1};
        vt[10] = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 3, 1, 0};
        vt[11] = '{1, 0, 0, 1, 8'h00, 8'h00, 1, 1, 0, 2, 0, 0};
        vt[12] = '{0, 1, 0, 1, 8'h00, 8'h01, 0, 0, 0, 3, 1, 0};
        vt[13] = '{1, 1, 1, 0, 8'h42, 8'h42, 0, 0, 0, 3, 0, 1};
        vt[14] = '{0, 1, 1, 0, 8'hF0, 8'hF0, 0, 0, 0, 3, 0, 1};
        vt[15] = '{1, 0, 0, 0, 8'h00, 8'hEF, 0, 0, 0, 3, 1, 0};
        vt[16] = '{1, 1, 0, 0, 8'h00, 8'hF0, 0, 0, 0, 3, 1, 0};
        vt[17] = '{0, 0, 1, 0, 8'hFF, 8'hFF, 0, 0, 0, 3, 0, 1};
        vt[18] = '{0, 1, 0, 0, 8'h00, 8'hFF, 1, 0, 1, 2, 0, 0};
        vt[19] = '{1, 0, 0, 0, 8'h00, 8'hFE, 0, 0, 1, 3, 1, 0};

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_load", cnt_load, 0);
        chk("rst_en", cnt_en, 1);
        chk("rst_ack", ack, 0);
        rst_n = 1;
        @(negedge clk);
        chk("init_q", cnt_q, 8'hFF);
        chk("init_busy", busy, 0);
        chk("init_load", cnt_load, 1);
        chk("init_ack", ack, 0);
        chk("init_flags", {ovf, unf}, 2'b00);

        for (int i = 0; i < 20; i++) apply(vt[i], i);

        // Push held through the busy phase: one ack, one decrement
        push = 1;
        @(negedge clk);
        chk("busy_hold_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        push = 0;
        chk("busy_hold_ack", ack, 1);
        chk("busy_hold_q", cnt_q, 8'hFD);
        begin
            int extra = 0;
            repeat (4) begin
                @(negedge clk);
                if (ack) extra++;
            end
            chk("busy_hold_no_2nd_ack", extra, 0);
        end
        chk("busy_hold_q_stable", cnt_q, 8'hFD);

        // Reset during STEP aborts the request
        push = 1;
        @(negedge clk);
        push = 0;
        chk("abort_in_step", cnt_en, 0);
        #2 rst_n = 0;
        #1;
        chk("abort_busy", busy, 1);
        chk("abort_load", cnt_load, 0);
        chk("abort_en", cnt_en, 1);
        chk("abort_ack", ack, 0);
        chk("abort_flags", {ovf, unf, err}, 3'b000);
        repeat (2) @(negedge clk);
        rst_n = 1;
        begin
            int acks = 0;
            repeat (6) begin
                @(negedge clk);
                if (ack) acks++;
            end
            chk("abort_no_ack", acks, 0);
        end
        chk("abort_q", cnt_q, 8'hFF);
        chk("abort_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
